// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and helpers for the programmable tick generator
package tick_gen_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Address width for a channel index; a single channel still gets a 1-bit select.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one programmable divider channel with shadowed divisor and one-shot halt
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W    = 20,
    parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_step,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_div,
    output logic             o_tick,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shd;
    logic             r_tick;
    logic             r_done;

    logic             w_adv;
    logic             w_term;
    logic             w_idle;
    logic [CNT_W-1:0] w_next_div;

    // A zero divisor never advances, so cnt stays parked at 0.
    assign w_adv      = i_step & ~r_done & (r_div_act != '0);
    assign w_term     = w_adv & (r_cnt == r_div_act - CNT_W'(1));
    assign w_idle     = (r_cnt == '0) & ~i_en;
    assign w_next_div = i_load ? i_load_div : r_div_shd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_div_act <= DIV_INIT;
            r_div_shd <= DIV_INIT;
        end else if (i_clr) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_div_act <= r_div_shd;
        end else begin
            if (i_load) begin
                r_div_shd <= i_load_div;
            end
            if (w_term) begin
                r_cnt     <= '0;
                r_tick    <= 1'b1;
                r_done    <= (i_mode == MODE_ONESHOT);
                r_div_act <= w_next_div;
            end else begin
                r_tick <= 1'b0;
                if (w_adv) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (i_load && w_idle) begin
                    r_div_act <= i_load_div;
                end
                if (r_done && (i_mode == MODE_PERIODIC)) begin
                    r_done <= 1'b0;
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_done = r_done;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/prog_tick_gen.sv
// rtl/prog_tick_gen.sv - multi-channel programmable tick generator with optional cascading
module prog_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int          NUM_CH  = 2,
    parameter int          CNT_W   = 20,
    parameter int unsigned DIV_RST = 1000000,
    parameter int          CASCADE = 0,
    localparam int         LCH_W   = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]       clr,
    input  logic                    load,
    input  logic [LCH_W-1:0]        load_ch,
    input  logic [CNT_W-1:0]        load_div,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*CNT_W-1:0] cnt
);

    logic [NUM_CH-1:0] w_step;
    logic [NUM_CH-1:0] w_load;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Cascaded channels count the registered tick of their predecessor.
        if ((CASCADE != 0) && (i > 0)) begin : g_casc
            assign w_step[i] = en[i] & tick[i-1];
        end else begin : g_free
            assign w_step[i] = en[i];
        end

        // Out-of-range addresses match no channel and are dropped.
        assign w_load[i] = load & (load_ch == LCH_W'(i));

        tick_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (CNT_W'(DIV_RST))
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_step     (w_step[i]),
            .i_en       (en[i]),
            .i_mode     (mode[i]),
            .i_clr      (clr[i]),
            .i_load     (w_load[i]),
            .i_load_div (load_div),
            .o_tick     (tick[i]),
            .o_done     (done[i]),
            .o_cnt      (cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
